uart_rx_core: RTL and testbench

- 8N1-style UART receiver that sits directly downstream of the baud tick generator (clkuart_pwm).
- On a start-bit falling edge it raises bps_en. It then consumes the generator's single-cycle mid-bit tick (clk_uart) to sample start, data and stop bits.
- A received byte is delivered through a one-entry holding register with valid/read handshake, framing-error pulse and sticky overrun flag.
- Feeds the APB/AHB UART register block, which reads rx_data and pulses rx_rd.

---
 rtl/uart_rx_core.sv | 149 ++++++++++++++
 tb/tb_uart_rx_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver driven by an external mid-bit tick generator.
// Delivers each good byte through a one-entry holding register with valid/read handshake.
module uart_rx_core #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       rxd,
    input  logic       clk_uart,
    input  logic       rx_rd,
    output logic       bps_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic                   rxd_meta_q, rxd_s_q, rxd_d_q;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   bps_en_q, bps_en_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   fall;
    logic                   load;
    logic                   rd_ok;
    logic [7:0]             data_ext;

    assign fall  = rxd_d_q & ~rxd_s_q;
    assign rd_ok = rx_rd & rx_valid_q;

    always_comb begin
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = shift_q;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        bps_en_d    = bps_en_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d  = StStart;
                    bps_en_d = 1'b1;
                end
            end
            StStart: begin
                if (clk_uart) begin
                    if (!rxd_s_q) begin
                        state_d = StData;
                        cnt_d   = 3'd0;
                    end else begin
                        // Line was high again at mid start bit: treat as a glitch.
                        state_d  = StIdle;
                        bps_en_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (clk_uart) begin
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (clk_uart) begin
                    state_d  = StIdle;
                    bps_en_d = 1'b0;
                    if (rxd_s_q) begin
                        load = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                bps_en_d = 1'b0;
            end
        endcase
    end

    // A load always wins over a same-cycle read; overrun only when the old byte was never taken.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (load) begin
            rx_data_d  = data_ext;
            rx_valid_d = 1'b1;
        end else if (rd_ok) begin
            rx_valid_d = 1'b0;
        end
        if (load && rx_valid_q && !rx_rd) begin
            overrun_d = 1'b1;
        end else if (rd_ok) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_d_q     <= 1'b1;
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= 3'd0;
            bps_en_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            rxd_d_q     <= rxd_s_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            bps_en_q    <= bps_en_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bps_en    = bps_en_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: behavioural 16-clk/bit baud tick model, vector table,
// corner-case sequences and randomized frames against a frame-level model.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       rxd;
    logic       clk_uart;
    logic       rx_rd;
    logic       bps_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    logic [3:0] bcnt = 4'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_before;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_core #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .rxd       (rxd),
        .clk_uart  (clk_uart),
        .rx_rd     (rx_rd),
        .bps_en    (bps_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Baud generator model: first tick half a bit after bps_en rises, then every 16 clocks.
    always @(posedge clk) begin
        if (!bps_en) bcnt <= 4'd0;
        else         bcnt <= bcnt + 4'd1;
    end
    assign clk_uart = bps_en && (bcnt == 4'd7);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rd_pulse();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic model_rd();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    // Sends one frame at 16 clk/bit, counting frame_err cycles seen during it.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int fe_cycles);
        logic [9:0] bits;
        logic       prev_v;
        bits      = {stop, b, 1'b0};
        fe_cycles = 0;
        prev_v    = rx_valid;
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            repeat (16) begin
                @(negedge clk);
                if (frame_err) fe_cycles++;
                if (rx_valid && !prev_v) check("bps_en_at_valid_rise", 32'(bps_en), 32'(0));
                prev_v = rx_valid;
            end
        end
        rxd = 1'b1;
    endtask

    task automatic check_model(input string tag, input int fe, input int exp_fe);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_frame_err_cycles"}, 32'(fe), 32'(exp_fe));
        check({tag, "_bps_en_idle"}, 32'(bps_en), 32'(0));
    endtask

    initial begin
        int fe;
        int hi;
        int n;
        logic [7:0] b;
        logic       stop;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 0, 1'b1};
        vecs[4] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 0, 1'b0};
        vecs[5] = '{8'h44, 1'b0, 1'b0, 8'h33, 1'b1, 1, 1'b0};
        // exp_fe holds 1 for a bad stop bit, 0 otherwise
        vecs[0].exp_fe = 0;

        RSTn  = 1'b0;
        rxd   = 1'b1;
        rx_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_bps_en", 32'(bps_en), 32'(0));
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_rx_valid", 32'(rx_valid), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_overrun", 32'(overrun), 32'(0));
        RSTn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rd_before) rd_pulse();
            repeat (2) @(negedge clk);
            send_frame(vecs[i].data, vecs[i].stop, fe);
            check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_fe_cycles", i), 32'(fe), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_bps_en", i), 32'(bps_en), 32'(0));
        end
        m_data  = 8'h33;
        m_valid = 1'b1;
        m_ovr   = 1'b0;

        // Read clears valid on the following cycle; a read of an empty register is ignored.
        rd_pulse();
        model_rd();
        check("rd_clears_valid", 32'(rx_valid), 32'(0));
        rd_pulse();
        check("rd_empty_valid", 32'(rx_valid), 32'(0));
        check("rd_empty_data", 32'(rx_data), 32'(8'h33));

        // Short low glitch: bps_en up for half a bit, no flags.
        rxd = 1'b0;
        hi  = 0;
        fe  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bps_en) hi++;
            if (frame_err) fe++;
            if (c == 3) rxd = 1'b1;
        end
        check("glitch_bps_cycles", 32'(hi), 32'(8));
        check_model("glitch", fe, 0);

        // Read lands exactly in the load cycle of a second byte.
        send_frame(8'h77, 1'b1, fe);
        model_frame(8'h77, 1'b1);
        check_model("pending", fe, 0);
        n = 0;
        fork
            send_frame(8'h5A, 1'b1, fe);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (clk_uart) begin
                        n++;
                        if (n == 10) begin
                            rx_rd = 1'b1;
                            @(negedge clk);
                            rx_rd = 1'b0;
                            break;
                        end
                    end
                end
            end
        join
        check("rd_load_tick_found", 32'(n), 32'(10));
        m_data  = 8'h5A;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
        check_model("rd_in_load", fe, 0);

        // Reset during data bit 4 of 0xFF, then a clean frame.
        fork
            send_frame(8'hFF, 1'b1, fe);
            begin
                repeat (16 * 5 + 8) @(negedge clk);
                RSTn = 1'b0;
                #1;
                check("midreset_bps_en", 32'(bps_en), 32'(0));
                check("midreset_rx_data", 32'(rx_data), 32'(0));
                check("midreset_rx_valid", 32'(rx_valid), 32'(0));
                check("midreset_frame_err", 32'(frame_err), 32'(0));
                check("midreset_overrun", 32'(overrun), 32'(0));
                repeat (3) @(negedge clk);
                RSTn = 1'b1;
            end
        join
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h81, 1'b1, fe);
        model_frame(8'h81, 1'b1);
        check_model("after_reset", fe, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rd_pulse();
                model_rd();
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, fe);
            model_frame(b, stop);
            check_model($sformatf("rand%0d", i), fe, stop ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
